// File: rtl/sdram_arbiter.sv
// Arbiter for the shared single-transaction SDRAM port: port 0 is urgent (audio),
// the others rotate round-robin, and a run counter stops port 0 from starving them.
module sdram_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int MAX_URGENT_RUN = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_finished,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      proto_err,
  output logic                      sdram_read,
  output logic                      sdram_write,
  output logic [ADDR_W-1:0]         sdram_addr,
  output logic [DATA_W-1:0]         sdram_writedata,
  input  logic [DATA_W-1:0]         sdram_readdata,
  input  logic                      sdram_finished
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_URGENT_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_URGENT_RUN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state, state_nxt;

  logic [PTR_W-1:0]  rr_ptr, winner, cand_idx;
  logic [CNT_W-1:0]  urgent_cnt;
  logic [NUM_REQ-1:0] pending;
  logic              others, urgent_win, found;
  int                cand;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_writedata[g*DATA_W +: DATA_W];
  end

  assign pending    = req_read | req_write;
  assign others     = |pending[NUM_REQ-1:1];
  assign urgent_win = pending[0] && ((urgent_cnt < CNT_MAX) || !others);

  // Round-robin over 1..NUM_REQ-1 starting after rr_ptr; port 0 never enters the rotation.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (urgent_win) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
        cand_idx = PTR_W'(cand);
        if (!found && pending[cand_idx]) begin
          winner = cand_idx;
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (sdram_finished) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_readdata    <= '0;
      req_finished    <= '0;
      grant           <= '0;
      busy            <= 1'b0;
      proto_err       <= 1'b0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
      rr_ptr          <= PTR_LAST;
      urgent_cnt      <= '0;
    end else begin
      req_finished <= '0;
      case (state)
        IDLE: if (found) begin
          sdram_addr      <= addr_arr[winner];
          sdram_writedata <= data_arr[winner];
          grant           <= NUM_REQ'(1) << winner;
          busy            <= 1'b1;
          sdram_write     <= req_write[winner];
          sdram_read      <= !req_write[winner];
          if (req_read[winner] && req_write[winner]) proto_err <= 1'b1;
          if (urgent_win) begin
            // The run only counts while someone else is actually waiting.
            if (!others)                  urgent_cnt <= '0;
            else if (urgent_cnt < CNT_MAX) urgent_cnt <= urgent_cnt + 1'b1;
          end else begin
            rr_ptr     <= winner;
            urgent_cnt <= '0;
          end
        end
        BUSY: if (sdram_finished) begin
          if (sdram_read) req_readdata <= sdram_readdata;
          req_finished <= grant;
          grant        <= '0;
          busy         <= 1'b0;
          sdram_read   <= 1'b0;
          sdram_write  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus queues expected grants/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sdram_arbiter;
  localparam int NUM_REQ = 5, ADDR_W = 23, DATA_W = 32, MAX_URGENT_RUN = 4;

  logic i_clk = 1'b0, i_rst = 1'b0;
  logic [NUM_REQ-1:0]        req_read = '0, req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_writedata = '0;
  logic [DATA_W-1:0]         req_readdata, sdram_writedata, sdram_readdata;
  logic [NUM_REQ-1:0]        req_finished, grant;
  logic                      busy, proto_err, sdram_read, sdram_write, sdram_finished;
  logic [ADDR_W-1:0]         sdram_addr;

  sdram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                  .MAX_URGENT_RUN(MAX_URGENT_RUN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_writedata(req_writedata), .req_readdata(req_readdata),
    .req_finished(req_finished), .grant(grant), .busy(busy), .proto_err(proto_err),
    .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
    .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_finished(sdram_finished));

  always #5 i_clk = ~i_clk;

  typedef struct { int port; logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } gexp_t;
  typedef struct { int port; logic [DATA_W-1:0] rdata; } fexp_t;
  gexp_t gq[$];
  fexp_t fq[$];

  int n_chk = 0, n_pass = 0, fin_seen = 0;
  int man_req = 0, man_done = 0;
  logic [DATA_W-1:0] man_data = '0, bus_data = '0, last_rd = '0;
  logic bus_auto = 1'b0;
  int   bus_lat = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_port(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W]      = a;
    req_writedata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_txn(input int p, input logic wr, input logic fin);
    gexp_t g;
    fexp_t f;
    g.port = p; g.wr = wr;
    g.addr = req_addr[p*ADDR_W +: ADDR_W];
    g.wdata = req_writedata[p*DATA_W +: DATA_W];
    gq.push_back(g);
    if (fin) begin
      if (!wr) last_rd = bus_data;
      f.port = p; f.rdata = last_rd;
      fq.push_back(f);
    end
  endtask

  task automatic wait_fin(input int target);
    for (int c = 0; c < 500 && fin_seen < target; c++) @(negedge i_clk);
    check("fin_timeout", fin_seen, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readdata"}, req_readdata, 0);
    check({tag, "_finished"}, req_finished, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_cmd"}, {sdram_read, sdram_write}, 0);
    check({tag, "_addr"}, sdram_addr, 0);
    check({tag, "_wdata"}, sdram_writedata, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
    last_rd = '0;
  endtask

  // Bus model: auto-completes after bus_lat cycles, or emits a manual (spurious) pulse.
  initial begin
    int cnt;
    cnt = 0; sdram_finished = 1'b0; sdram_readdata = '0;
    forever begin
      @(posedge i_clk); #1;
      sdram_finished = 1'b0;
      if (man_req != man_done) begin
        man_done++;
        sdram_finished = 1'b1; sdram_readdata = man_data;
      end else if (bus_auto && busy) begin
        cnt++;
        if (cnt >= bus_lat) begin
          sdram_finished = 1'b1; sdram_readdata = bus_data; cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // Monitor
  initial begin
    logic busy_d;
    gexp_t g;
    fexp_t f;
    busy_d = 1'b0;
    forever begin
      @(negedge i_clk);
      if (busy && !busy_d) begin
        if (gq.size() == 0) check("unexpected_grant", grant, 0);
        else begin
          g = gq.pop_front();
          check("grant", grant, 64'(1) << g.port);
          check("sdram_write", sdram_write, g.wr);
          check("sdram_read", sdram_read, !g.wr);
          check("sdram_addr", sdram_addr, g.addr);
          if (g.wr) check("sdram_writedata", sdram_writedata, g.wdata);
        end
      end
      if (req_finished != 0) begin
        if (fq.size() == 0) check("unexpected_finished", req_finished, 0);
        else begin
          f = fq.pop_front();
          check("req_finished", req_finished, 64'(1) << f.port);
          check("req_readdata", req_readdata, f.rdata);
          fin_seen++;
        end
      end
      busy_d = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    #1 i_rst = 1'b1;
    #2 check_all_zero("reset");
    @(negedge i_clk); i_rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_port(i, 23'h10000 + 23'(i * 16), 32'hA0000000 + 32'(i));
    set_port(3, 23'h000123, 32'h0);

    // Single read, bus latency 5
    bus_auto = 1'b1; bus_lat = 5; bus_data = 32'hDEADBEEF;
    base = fin_seen;
    expect_txn(3, 1'b0, 1'b1);
    @(negedge i_clk); req_read[3] = 1'b1;
    @(posedge i_clk); #1;
    check("t1_latency_read", sdram_read, 1);
    check("t1_latency_addr", sdram_addr, 23'h000123);
    wait_fin(base + 1);
    req_read[3] = 1'b0;
    @(negedge i_clk);
    check("t1_pulse_width", req_finished, 0);

    // Round-robin 1,2,4
    do_reset();
    bus_lat = 2; bus_data = 32'h0BADF00D;
    base = fin_seen;
    for (int r = 0; r < 2; r++) begin
      expect_txn(1, 1'b1, 1'b1); expect_txn(2, 1'b1, 1'b1); expect_txn(4, 1'b0, 1'b1);
    end
    @(negedge i_clk); req_write[1] = 1'b1; req_write[2] = 1'b1; req_read[4] = 1'b1;
    wait_fin(base + 6);
    req_write = '0; req_read = '0;

    // Urgent starvation guard, then port 0 alone
    bus_data = 32'h600DCAFE;
    base = fin_seen;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MAX_URGENT_RUN; k++) expect_txn(0, 1'b0, 1'b1);
      expect_txn(2, 1'b0, 1'b1);
    end
    for (int k = 0; k < 6; k++) expect_txn(0, 1'b0, 1'b1);
    @(negedge i_clk); req_read[0] = 1'b1; req_read[2] = 1'b1;
    wait_fin(base + 10);
    req_read[2] = 1'b0;
    wait_fin(base + 16);
    req_read[0] = 1'b0;

    // Read and write together on the winner
    check("t4_proto_before", proto_err, 0);
    set_port(1, 23'h000456, 32'h0000BEEF);
    base = fin_seen;
    expect_txn(1, 1'b1, 1'b1);
    @(negedge i_clk); req_read[1] = 1'b1; req_write[1] = 1'b1;
    @(posedge i_clk); #1;
    check("t4_proto_err", proto_err, 1);
    check("t4_cmd", {sdram_read, sdram_write}, 2'b01);
    wait_fin(base + 1);
    req_read[1] = 1'b0; req_write[1] = 1'b0;
    repeat (3) @(negedge i_clk);
    check("t4_proto_sticky", proto_err, 1);

    // Reset while port 2 owns the bus
    bus_auto = 1'b0;
    expect_txn(2, 1'b0, 1'b0);
    @(negedge i_clk); req_read[2] = 1'b1;
    for (int c = 0; c < 20 && !busy; c++) @(negedge i_clk);
    check("t5_busy", busy, 1);
    check("t5_grant", grant, 5'b00100);
    req_read[2] = 1'b0;
    #2 i_rst = 1'b1;
    #1 check_all_zero("t5_async");
    @(negedge i_clk); i_rst = 1'b0; last_rd = '0;
    man_data = 32'h55AA55AA; man_req++;
    @(negedge i_clk); @(negedge i_clk);
    check("t5_late_fin", req_finished, 0);
    check("t5_late_rdata", req_readdata, 0);
    bus_auto = 1'b1; bus_lat = 2; bus_data = 32'h13579BDF;
    base = fin_seen;
    expect_txn(1, 1'b0, 1'b1); expect_txn(3, 1'b0, 1'b1);
    @(negedge i_clk); req_read[1] = 1'b1; req_read[3] = 1'b1;
    wait_fin(base + 1);
    req_read[1] = 1'b0;
    wait_fin(base + 2);
    req_read[3] = 1'b0;

    // Spurious finished while idle
    repeat (3) @(negedge i_clk);
    man_data = 32'hCAFEF00D; man_req++;
    @(negedge i_clk);
    check("t6_fin_a", req_finished, 0);
    @(negedge i_clk);
    check("t6_fin_b", req_finished, 0);
    check("t6_rdata", req_readdata, last_rd);

    repeat (4) @(negedge i_clk);
    check("gq_drained", gq.size(), 0);
    check("fq_drained", fq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
